// File: rtl/inc_pipe_chain_if.sv
// Handshake bundle for inc_pipe_chain: producer side (in_*) and consumer side (out_*).
// The master modport is the environment that drives words in and takes words out.
interface inc_pipe_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inc_pipe_chain.sv
// Pipelined increment chain: each of STAGES stages adds INCR, with per-stage backpressure,
// synchronous flush, occupancy readout and a saturating output match counter.
module inc_pipe_chain #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 5,
    parameter  int INCR   = 1,
    parameter  int MATCH  = 3,
    parameter  int CNT_W  = 16,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inc_pipe_chain_if.slave      bus,
    input  logic                 flush,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count
);

    localparam logic [WIDTH-1:0] INCR_W  = WIDTH'(INCR);
    localparam logic [WIDTH-1:0] MATCH_W = WIDTH'(MATCH);

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              r_match_pulse;
    logic [CNT_W-1:0]  r_match_count;

    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_dn;
    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_src [STAGES];
    logic [OCC_W-1:0]  w_occ;
    logic              w_match;

    // w_dn[k] is the readiness of whatever sits after stage k; w_rdy[k] adds "stage k is empty".
    always_comb begin : rdy_chain
        logic acc;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_rdy = '0;
        w_dn  = '0;
        acc   = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_dn[k]  = acc;
            acc      = !r_v[k] || acc;
            w_rdy[k] = acc;
        end
    end

    always_comb begin : load_ctrl
        w_load    = '0;
        w_src[0]  = bus.in_data;
        w_load[0] = bus.in_valid && bus.in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = r_v[k-1] && w_rdy[k];
            w_src[k]  = r_d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every stage sees pre-edge neighbour values.
        if (!rst_n) begin
            r_v <= '0;
            // NOTE: the data array is reset too, because out_data must read 0 straight after reset.
            for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= 1'b1;
                    r_d[k] <= w_src[k] + INCR_W;
                end else if (w_dn[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_rdy[0] && !flush;
    assign bus.out_valid = r_v[STAGES-1] && !flush;
    assign bus.out_data  = r_d[STAGES-1];

    assign w_match = bus.out_valid && bus.out_ready && (bus.out_data == MATCH_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_pulse <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_match_pulse <= w_match;
            if (w_match && (r_match_count != '1)) r_match_count <= r_match_count + CNT_W'(1);
        end
    end

    always_comb begin : popcount
        w_occ = '0;
        for (int k = 0; k < STAGES; k++) w_occ = w_occ + OCC_W'(r_v[k]);
    end

    assign occupancy   = w_occ;
    assign match_pulse = r_match_pulse;
    assign match_count = r_match_count;

endmodule

// File: tb/tb_inc_pipe_chain.sv
// Bench for inc_pipe_chain: two instances (default and CNT_W=2) driven identically and
// scored against a queue model of in-flight words with their earliest output cycle.
module tb_inc_pipe_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;
    localparam int INCR   = 1;
    localparam logic [31:0] MATCH = 32'd3;

    typedef struct {
        logic [31:0] data;
        int          avail;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    inc_pipe_chain_if #(.WIDTH(WIDTH)) bus_a ();
    inc_pipe_chain_if #(.WIDTH(WIDTH)) bus_b ();

    logic [2:0]  occ_a, occ_b;
    logic        mp_a, mp_b;
    logic [15:0] mc_a;
    logic [1:0]  mc_b;

    inc_pipe_chain dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .flush(flush),
        .occupancy(occ_a), .match_pulse(mp_a), .match_count(mc_a)
    );

    inc_pipe_chain #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .flush(flush),
        .occupancy(occ_b), .match_pulse(mp_b), .match_count(mc_b)
    );

    word_t       q[$];
    logic [31:0] obs_d[$];
    int          obs_c[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          exp_pulse = 1'b0;
    int          exp_cnt = 0;

    task automatic drive(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        bus_a.in_valid = iv; bus_b.in_valid = iv;
        bus_a.in_data = d;   bus_b.in_data = d;
        bus_a.out_ready = ordy; bus_b.out_ready = ordy;
        flush = fl;
    endtask

    // One clock cycle of stimulus, scored against the in-flight word queue.
    task automatic step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        bit    exp_rdy, exp_ov, issue, match;
        word_t w;
        int    cnt_b;
        cnt_b = (exp_cnt > 3) ? 3 : exp_cnt;
        n_vec++; if (occ_a !== 3'(q.size())) begin n_err++; $display("FAIL occupancy_a cyc=%0d got %0d want %0d", cyc, occ_a, q.size()); end
        n_vec++; if (occ_b !== 3'(q.size())) begin n_err++; $display("FAIL occupancy_b cyc=%0d got %0d want %0d", cyc, occ_b, q.size()); end
        n_vec++; if (mp_a !== exp_pulse) begin n_err++; $display("FAIL match_pulse_a cyc=%0d got %b want %b", cyc, mp_a, exp_pulse); end
        n_vec++; if (mp_b !== exp_pulse) begin n_err++; $display("FAIL match_pulse_b cyc=%0d got %b want %b", cyc, mp_b, exp_pulse); end
        n_vec++; if (mc_a !== 16'(exp_cnt)) begin n_err++; $display("FAIL match_count_a cyc=%0d got %0d want %0d", cyc, mc_a, exp_cnt); end
        n_vec++; if (mc_b !== 2'(cnt_b)) begin n_err++; $display("FAIL match_count_b cyc=%0d got %0d want %0d", cyc, mc_b, cnt_b); end

        drive(iv, d, ordy, fl);
        #1;
        exp_rdy = !fl && ((q.size() < STAGES) || ordy);
        exp_ov  = 1'b0;
        if (!fl && q.size() > 0) exp_ov = (cyc >= q[0].avail);

        n_vec++; if (bus_a.in_ready !== exp_rdy) begin n_err++; $display("FAIL in_ready_a cyc=%0d got %b want %b", cyc, bus_a.in_ready, exp_rdy); end
        n_vec++; if (bus_b.in_ready !== exp_rdy) begin n_err++; $display("FAIL in_ready_b cyc=%0d got %b want %b", cyc, bus_b.in_ready, exp_rdy); end
        n_vec++; if (bus_a.out_valid !== exp_ov) begin n_err++; $display("FAIL out_valid_a cyc=%0d got %b want %b", cyc, bus_a.out_valid, exp_ov); end
        n_vec++; if (bus_b.out_valid !== exp_ov) begin n_err++; $display("FAIL out_valid_b cyc=%0d got %b want %b", cyc, bus_b.out_valid, exp_ov); end
        if (exp_ov) begin
            n_vec++; if (bus_a.out_data !== q[0].data) begin n_err++; $display("FAIL out_data_a cyc=%0d got %h want %h", cyc, bus_a.out_data, q[0].data); end
            n_vec++; if (bus_b.out_data !== q[0].data) begin n_err++; $display("FAIL out_data_b cyc=%0d got %h want %h", cyc, bus_b.out_data, q[0].data); end
        end

        if (bus_a.out_valid === 1'b1 && ordy) begin
            obs_d.push_back(bus_a.out_data);
            obs_c.push_back(cyc);
        end

        issue = exp_ov && ordy;
        match = 1'b0;
        if (issue) begin
            w = q.pop_front();
            match = (w.data == MATCH);
            if (q.size() > 0) begin
                w = q.pop_front();
                if (w.avail < cyc + 1) w.avail = cyc + 1;
                q.push_front(w);
            end
        end
        if (iv && exp_rdy) begin
            w.data  = d + 32'(STAGES * INCR);
            w.avail = cyc + STAGES;
            q.push_back(w);
        end
        if (fl) q.delete();
        exp_pulse = match;
        if (match && exp_cnt < 65535) exp_cnt++;

        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic apply_reset();
        drive(1'b1, $urandom, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        q.delete();
        exp_cnt = 0;
        exp_pulse = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus_a.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus_a.in_ready); end
        n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus_a.out_valid); end
        n_vec++; if (bus_a.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus_a.out_data); end
        n_vec++; if (occ_a !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occ_a); end
        n_vec++; if (mp_a !== 1'b0) begin n_err++; $display("FAIL reset_match_pulse got %b want 0", mp_a); end
        n_vec++; if (mc_a !== 16'd0) begin n_err++; $display("FAIL reset_match_count got %0d want 0", mc_a); end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        n_vec++; if (bus_a.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_flush got %b want 0", bus_a.in_ready); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_single();
        int acc_c;
        obs_d.delete(); obs_c.delete();
        acc_c = cyc;
        step(1'b1, 32'h1234, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (obs_d.size() != 1) begin n_err++; $display("FAIL single_count got %0d want 1", obs_d.size()); end
        if (obs_d.size() == 1) begin
            n_vec++; if (obs_d[0] !== 32'h1239) begin n_err++; $display("FAIL single_data got %h want 00001239", obs_d[0]); end
            n_vec++; if (obs_c[0] != acc_c + STAGES) begin n_err++; $display("FAIL single_latency got %0d want %0d", obs_c[0] - acc_c, STAGES); end
        end
        n_vec++; if (occ_a !== 3'd0) begin n_err++; $display("FAIL single_occupancy got %0d want 0", occ_a); end
    endtask

    task automatic test_back_to_back();
        obs_d.delete(); obs_c.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (obs_d.size() != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", obs_d.size()); end
        if (obs_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_vec++; if (obs_d[i] !== 32'(i + 5)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, obs_d[i], i + 5); end
                n_vec++; if (obs_c[i] != obs_c[0] + i) begin n_err++; $display("FAIL b2b_gap[%0d] got cycle %0d want %0d", i, obs_c[i], obs_c[0] + i); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] sent[8];
        obs_d.delete(); obs_c.delete();
        for (int i = 0; i < 8; i++) begin
            sent[i] = $urandom;
            if (sent[i] == 32'hFFFF_FFFE) sent[i] = 32'h10;
            step(1'b1, sent[i], 1'b0, 1'b0);
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        #1;
        n_vec++; if (bus_a.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b want 0", bus_a.in_ready); end
        n_vec++; if (occ_a !== 3'd5) begin n_err++; $display("FAIL stall_occupancy got %0d want 5", occ_a); end
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (obs_d.size() != 5) begin n_err++; $display("FAIL stall_drain_count got %0d want 5", obs_d.size()); end
        if (obs_d.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_vec++; if (obs_d[i] !== sent[i] + 32'd5) begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", i, obs_d[i], sent[i] + 32'd5); end
            end
        end
    endtask

    task automatic test_wrap_match();
        int cnt0;
        cnt0 = exp_cnt;
        obs_d.delete(); obs_c.delete();
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        repeat (7) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (obs_d.size() != 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", obs_d.size()); end
        if (obs_d.size() == 1) begin
            n_vec++; if (obs_d[0] !== 32'h0000_0003) begin n_err++; $display("FAIL wrap_data got %h want 00000003", obs_d[0]); end
        end
        n_vec++; if (mc_a !== 16'(cnt0 + 1)) begin n_err++; $display("FAIL wrap_match_count got %0d want %0d", mc_a, cnt0 + 1); end
    endtask

    task automatic test_flush();
        int cnt0;
        cnt0 = exp_cnt;
        obs_d.delete(); obs_c.delete();
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b0);
        step(1'b1, 32'h66, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        n_vec++; if (occ_a !== 3'd0) begin n_err++; $display("FAIL flush_occupancy got %0d want 0", occ_a); end
        n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", bus_a.out_valid); end
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (obs_d.size() != 0) begin n_err++; $display("FAIL flush_leak got %0d words want 0", obs_d.size()); end
        n_vec++; if (mc_a !== 16'(cnt0)) begin n_err++; $display("FAIL flush_match_count got %0d want %0d", mc_a, cnt0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
            step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate_and_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++; if (mc_b !== 2'd3) begin n_err++; $display("FAIL sat_count_b got %0d want 3", mc_b); end
        n_vec++; if (mc_a !== 16'd5) begin n_err++; $display("FAIL sat_count_a got %0d want 5", mc_a); end
        for (int i = 0; i < 6; i++) step(1'b1, 32'($urandom_range(16, 1000)), 1'b0, 1'b0);
        apply_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        n_vec++; if (bus_a.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus_a.out_valid); end
        n_vec++; if (occ_a !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occ_a); end
        n_vec++; if (mc_a !== 16'd0) begin n_err++; $display("FAIL rst_count_a got %0d want 0", mc_a); end
        n_vec++; if (mc_b !== 2'd0) begin n_err++; $display("FAIL rst_count_b got %0d want 0", mc_b); end
        n_vec++; if (bus_a.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0", bus_a.out_data); end
        n_vec++; if (mp_a !== 1'b0) begin n_err++; $display("FAIL rst_match_pulse got %b want 0", mp_a); end
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap_match();
        test_flush();
        test_random();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
